reg_file: RTL

Register file sitting directly downstream of the system controller: it executes the controller's write and read commands and returns read data with a one-cycle valid pulse. It also exposes its four low registers continuously: ALU operands A/B, UART configuration and clock-divider ratio. These feed the ALU, UART and clock divider without a read transaction.

---
 rtl/reg_file_if.sv | 23 ++
 rtl/reg_file.sv | 68 ++++++
 2 files changed

// File: rtl/reg_file_if.sv
// Command/response bus between the system controller (master) and the register file (slave).
// Valid/ready note: there is no back-pressure. WrEn/RdEn are sampled every rising edge, and RdData is qualified only by RdData_Valid.
interface reg_file_if #(
   parameter int WIDTH = 8,
   parameter int ADDR  = 4
);
   logic             WrEn;
   logic             RdEn;
   logic [ADDR-1:0]  Address;
   logic [WIDTH-1:0] WrData;
   logic [WIDTH-1:0] RdData;
   logic             RdData_Valid;

   modport master (
      output WrEn, RdEn, Address, WrData,
      input  RdData, RdData_Valid
   );

   modport slave (
      input  WrEn, RdEn, Address, WrData,
      output RdData, RdData_Valid
   );
endinterface

// File: rtl/reg_file.sv
// Flop-based register file that executes controller write/read commands.
// The four low registers are exported continuously to the ALU, the UART and the clock divider.
module reg_file #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int ADDR  = 4
) (
   input  logic             CLK,
   input  logic             RST,
   reg_file_if.slave        bus,
   output logic [WIDTH-1:0] REG0,
   output logic [WIDTH-1:0] REG1,
   output logic [WIDTH-1:0] REG2,
   output logic [WIDTH-1:0] REG3
);
   // UART config resets to prescale 32, parity enabled, even parity. The divider ratio resets to 32.
   localparam logic [WIDTH-1:0] REG2_RST = WIDTH'(8'h81);
   localparam logic [WIDTH-1:0] REG3_RST = WIDTH'(8'd32);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic [ADDR-1:0]  addr;
   logic             wr_cmd;
   logic             rd_cmd;

   assign addr   = bus.Address;
   // A simultaneous write and read request is illegal, so it performs neither action.
   assign wr_cmd = bus.WrEn && !bus.RdEn;
   assign rd_cmd = bus.RdEn && !bus.WrEn;

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_cmd) begin
         rd_data_d  = mem_q[addr];
         rd_valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= (i == 2) ? REG2_RST : (i == 3) ? REG3_RST : '0;
         end
      end else if (wr_cmd) begin
         mem_q[addr] <= bus.WrData;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign bus.RdData       = rd_data_q;
   assign bus.RdData_Valid = rd_valid_q;

   assign REG0 = mem_q[0];
   assign REG1 = mem_q[1];
   assign REG2 = mem_q[2];
   assign REG3 = mem_q[3];
endmodule
